// File: rtl/seg7_pkg.sv
// Shared glyph table and decode rules for the seven-segment scan driver.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
// Segment vectors are ordered {a,b,c,d,e,f,g}, bit 6 = a, active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Scan index width for a given digit count: IDX_W = $clog2(DIGITS).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Nibble to glyph; in BCD mode the six non-decimal codes show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] v, input logic hex_en);
        logic [6:0] s;
        case (v)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            default: s = SEG_F;
        endcase
        if (v > 4'd9 && !hex_en) s = SEG_DASH;
        return s;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-glyph decoder (BCD or hex).
// Latency: 0 cycles. Backpressure: none.
// Ports: nibble (4b value), hex_en (1 = hex glyphs, 0 = dash for 10-15), seg (active-high {a..g}).
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_en,
    output logic [6:0] seg
);

    assign seg = seg_decode(nibble, hex_en);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment scanner with frame-synchronous (tear-free) value update.
// Latency: pins are registered, one cycle behind the scan index; loads show from the next frame.
// Backpressure: none; load is always accepted, the last load in a frame wins.
// Ports: clk, clrn (async active-low), digits_in (nibble i = digit i, digit 0 rightmost), load,
//        hex_en, lzb_en (leading-zero blanking), seg {a..g}, an (one-hot digit enable), frame_tick.
// Build option: define SEG7_DEADTIME_EN to blank an during the first cycle of every slot (DIV>=2).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DIV            = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic                  load,
    input  logic                  hex_en,
    input  logic                  lzb_en,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int IDX_W = idx_width(DIGITS);
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    // XOR masks: inactive level of each pin group, also used to flip polarity.
    localparam logic [6:0]        SEG_POL  = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_POL   = {DIGITS{AN_ACTIVE_LOW}};

    if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
        $error("seg7_scan_driver: DIGITS must be 2..8");
    end
    if (DIV < 1 || DIV > 65535) begin : g_bad_div
        $error("seg7_scan_driver: DIV must be 1..65535");
    end
`ifdef SEG7_DEADTIME_EN
    if (DIV < 2) begin : g_bad_deadtime
        $error("seg7_scan_driver: SEG7_DEADTIME_EN needs DIV >= 2");
    end
`endif

    logic [PRE_W-1:0]    presc;
    logic [IDX_W-1:0]    idx;
    logic                pending;
    logic [4*DIGITS-1:0] staging;
    logic [4*DIGITS-1:0] display;
    logic                slot_end;
    logic                wrap;
    logic [3:0]          nibble;
    logic                lead_zero;
    logic                blank;
    logic [DIGITS-1:0]   an_sel;
    logic [DIGITS-1:0]   an_next;
    logic [6:0]          glyph;

    assign slot_end = (presc == PRE_LAST);
    assign wrap     = slot_end && (idx == IDX_LAST);

    // Prescaler and scan index.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            presc <= '0;
            idx   <= '0;
        end else if (slot_end) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Staging and display registers; display only changes on the wrap so a frame never tears.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pending <= 1'b0;
            staging <= '0;
            display <= '0;
        end else begin
            if (load) staging <= digits_in;
            if (wrap) begin
                pending <= 1'b0;
                if (load)         display <= digits_in;
                else if (pending) display <= staging;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Digit select and leading-zero detection. Walking from the top digit down,
    // lead_zero holds "digits DIGITS-1..i are all zero" when digit i is visited.
    always_comb begin
        nibble    = 4'h0;
        lead_zero = 1'b1;
        blank     = 1'b0;
        an_sel    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (display[4*i +: 4] != 4'h0) lead_zero = 1'b0;
            if (idx == IDX_W'(i)) begin
                nibble    = display[4*i +: 4];
                an_sel[i] = 1'b1;
                blank     = lzb_en && (i != 0) && lead_zero;
            end
        end
    end

`ifdef SEG7_DEADTIME_EN
    // Anode off for the first count of each slot while seg settles on the new digit.
    assign an_next = (presc == '0) ? '0 : an_sel;
`else
    assign an_next = an_sel;
`endif

    seg7_decode u_decode (
        .nibble (nibble),
        .hex_en (hex_en),
        .seg    (glyph)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            seg        <= SEG_POL;
            an         <= AN_POL;
            frame_tick <= 1'b0;
        end else begin
            seg        <= (blank ? SEG_BLANK : glyph) ^ SEG_POL;
            an         <= an_next ^ AN_POL;
            frame_tick <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, DIV=4, active-high pins).
// The reference model works from the cycle count since reset: slot = count/DIV, frame = DIGITS slots.
// Expected pins after an edge come from the model's display value as it stood before that edge.
module tb_seg7_scan_driver;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int FRAME  = DIGITS * DIV;

    logic        clk;
    logic        clrn;
    logic [15:0] digits_in;
    logic        load;
    logic        hex_en;
    logic        lzb_en;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    seg7_scan_driver #(
        .DIGITS         (DIGITS),
        .DIV            (DIV),
        .SEG_ACTIVE_LOW (1'b0),
        .AN_ACTIVE_LOW  (1'b0)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .digits_in  (digits_in),
        .load       (load),
        .hex_en     (hex_en),
        .lzb_en     (lzb_en),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Glyphs 0-F straight from the display datasheet table.
    logic [6:0] glyph [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    int n_total;
    int n_pass;
    int n_fail;

    // Model state.
    int          k;        // cycles since reset release
    logic [15:0] m_disp;
    logic [15:0] m_stage;
    bit          m_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp_v, k);
        end
    endtask

    // One clock with the given load request; checks the pins after the edge.
    task automatic cyc(input bit ld, input logic [15:0] d);
        int         ix;
        logic [3:0] v;
        logic [6:0] es;
        logic [3:0] ea;
        bit         eft;
        load      = ld;
        digits_in = d;
        ix  = (k / DIV) % DIGITS;
        v   = 4'(m_disp >> (4 * ix));
        es  = (v < 4'd10 || hex_en) ? glyph[v] : 7'b0000001;
        if (lzb_en && ix > 0 && (m_disp >> (4 * ix)) == 16'h0) es = 7'b0000000;
        ea  = 4'(1 << ix);
        eft = (k % FRAME) == FRAME - 1;
        if ((k % FRAME) == FRAME - 1) begin
            if (ld)          m_disp = d;
            else if (m_pend) m_disp = m_stage;
            m_pend = 0;
        end else if (ld) begin
            m_stage = d;
            m_pend  = 1;
        end
        k++;
        @(posedge clk);
        #1;
        load = 1'b0;
        chk("seg", 32'(seg), 32'(es));
        chk("an", 32'(an), 32'(ea));
        chk("frame_tick", 32'(frame_tick), 32'(eft));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0);
    endtask

    task automatic idle_to(input int pos);
        while ((k % FRAME) != pos) cyc(1'b0, 16'h0);
    endtask

    task automatic model_reset();
        k       = 0;
        m_disp  = 16'h0;
        m_stage = 16'h0;
        m_pend  = 0;
    endtask

    initial begin : main
        logic [15:0] d;
        logic [3:0]  msk;
        bit          ld;
        clk       = 1'b0;
        clrn      = 1'b0;
        load      = 1'b0;
        digits_in = 16'h0;
        hex_en    = 1'b0;
        lzb_en    = 1'b0;
        n_total   = 0;
        n_pass    = 0;
        n_fail    = 0;
        model_reset();

        // Reset held for three cycles: everything off.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_seg", 32'(seg), 32'h0);
        chk("reset_an", 32'(an), 32'h0);
        chk("reset_tick", 32'(frame_tick), 32'h0);
        clrn = 1'b1;

        // BCD scan of 0123, shown from the frame after the load.
        cyc(1'b1, 16'h0123);
        idle(2 * FRAME - 1);

        // Tear-free: load in slot 1, held until the next wrap.
        idle_to(DIV + 1);
        cyc(1'b1, 16'h9876);
        idle_to(FRAME - 1);
        idle(1);
        // Load coincident with the wrap takes effect at once.
        idle_to(FRAME - 1);
        cyc(1'b1, 16'h5555);
        idle(FRAME);

        // Several loads within one frame: the last one wins.
        cyc(1'b1, 16'h1111);
        idle(3);
        cyc(1'b1, 16'h2222);
        idle_to(FRAME - 1);
        idle(FRAME + 1);

        // Hex versus BCD on ABCD.
        hex_en = 1'b1;
        cyc(1'b1, 16'hABCD);
        idle_to(FRAME - 1);
        idle(FRAME + 1);
        hex_en = 1'b0;
        idle(FRAME);

        // Leading-zero blanking.
        lzb_en = 1'b1;
        cyc(1'b1, 16'h0070);
        idle_to(FRAME - 1);
        idle(FRAME + 1);
        cyc(1'b1, 16'h0000);
        idle_to(FRAME - 1);
        idle(FRAME + 1);
        lzb_en = 1'b0;

        // Reset mid-scan with a load still pending: outputs drop asynchronously.
        cyc(1'b1, 16'h4321);
        idle_to(2 * DIV + 1);
        #2;
        clrn = 1'b0;
        #1;
        chk("midreset_seg", 32'(seg), 32'h0);
        chk("midreset_an", 32'(an), 32'h0);
        chk("midreset_tick", 32'(frame_tick), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        clrn = 1'b1;
        model_reset();
        idle(2 * FRAME);

        // Randomized loads and mode changes.
        for (int c = 0; c < 1000; c++) begin
            if ($urandom_range(0, 15) == 0) hex_en = ~hex_en;
            if ($urandom_range(0, 15) == 0) lzb_en = ~lzb_en;
            ld  = ($urandom_range(0, 7) == 0);
            d   = 16'($urandom);
            msk = 4'($urandom);
            for (int j = 0; j < 4; j++) if (!msk[j]) d[4*j +: 4] = 4'h0;
            cyc(ld, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
